// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
//   Shared definitions for the streaming neuron processing element:
//     - 2-bit state encoding for the neuron control FSM
//     - saturate(): clamps a sign-extended value into a WIDTH_OUT-bit signed
//       range and reports whether clamping occurred
//     - acc_width_ok(): elaboration-time check that the accumulator is wide
//       enough for the worst-case dot product, the bias and the output width
//   No ports (package).
// -----------------------------------------------------------------------------
package neuron_pkg;

  // State encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCUM  = ST_ACCUM,
    S_FINISH = ST_FINISH,
    S_HOLD   = ST_HOLD
  } state_e;

  // Working width of saturate(). Callers sign-extend into this width and
  // take the low WIDTH_OUT bits of the result.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] value;
    logic             flag;
  } sat_t;

  // Clamp x into [-2^(w_out-1), 2^(w_out-1)-1]; flag is set iff clamped.
  function automatic sat_t saturate(input logic signed [SAT_W-1:0] x,
                                    input int                      w_out);
    sat_t                    res;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = $signed((SAT_W'(1) << (w_out - 1)) - SAT_W'(1));
    // Two's complement: ~max == -max-1 == most negative representable value.
    min_v = ~max_v;
    res.value = x;
    res.flag  = 1'b0;
    if (x > max_v) begin
      res.value = max_v;
      res.flag  = 1'b1;
    end else if (x < min_v) begin
      res.value = min_v;
      res.flag  = 1'b1;
    end
    return res;
  endfunction

  // Accumulator must hold the full dot product without wrapping, the bias
  // plus a sign bit, and at least the output width. The output stage also
  // works one bit wider than the accumulator inside SAT_W.
  function automatic bit acc_width_ok(input int w_acc, input int w_in,
                                      input int w_w, input int w_b,
                                      input int w_out, input int in_size);
    return (w_acc >= w_in + w_w + $clog2(in_size)) &&
           (w_acc >= w_b + 1) &&
           (w_acc >= w_out) &&
           (w_acc + 1 <= SAT_W) &&
           (w_out < SAT_W);
  endfunction

endpackage

// File: rtl/lane_dot_sum.sv
// -----------------------------------------------------------------------------
// lane_dot_sum
//   Purely combinational LANES-wide signed multiply plus adder tree.
//   Ports:
//     in_data   [LANES*WIDTH_IN-1:0]  lane k at [(k+1)*WIDTH_IN-1 -: WIDTH_IN]
//     in_weight [LANES*WIDTH_W-1:0]   lane k packed the same way
//     sum       signed sum of all lane products,
//               WIDTH_IN+WIDTH_W+$clog2(LANES)+1 bits wide
// -----------------------------------------------------------------------------
module lane_dot_sum #(
  parameter int LANES    = 4,
  parameter int WIDTH_IN = 8,
  parameter int WIDTH_W  = 8
) (
  input  logic        [LANES*WIDTH_IN-1:0]               in_data,
  input  logic        [LANES*WIDTH_W-1:0]                in_weight,
  output logic signed [WIDTH_IN+WIDTH_W+$clog2(LANES):0] sum
);

  localparam int PROD_W = WIDTH_IN + WIDTH_W;
  localparam int SUM_W  = WIDTH_IN + WIDTH_W + $clog2(LANES) + 1;
  // Tree is padded up to a power of two; padding leaves are zero.
  localparam int NLEAF  = 1 << $clog2(LANES);

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  node [NLEAF];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [WIDTH_IN-1:0] a;
    logic signed [WIDTH_W-1:0]  b;
    assign a = in_data[gi*WIDTH_IN +: WIDTH_IN];
    assign b = in_weight[gi*WIDTH_W +: WIDTH_W];
    // Extend both operands first so the product is full precision.
    assign prod[gi] = PROD_W'(a) * PROD_W'(b);
  end

  // In-place pairwise reduction: each pass halves the number of live nodes,
  // giving a log2(NLEAF)-deep adder tree rather than a chain.
  always_comb begin
    for (int i = 0; i < NLEAF; i++) begin
      node[i] = '0;
      if (i < LANES) begin
        node[i] = SUM_W'(prod[i]);
      end
    end
    for (int step = 1; step < NLEAF; step = step * 2) begin
      for (int i = 0; i < NLEAF; i = i + 2 * step) begin
        node[i] = node[i] + node[i+step];
      end
    end
    sum = node[0];
  end

endmodule

// File: rtl/neuron_stream_pe.sv
// -----------------------------------------------------------------------------
// neuron_stream_pe
//   Streaming neuron: accumulates a signed dot product of IN_SIZE input/weight
//   pairs arriving LANES pairs per beat, adds a bias, optionally applies ReLU,
//   saturates to WIDTH_OUT and presents the result on a valid/ready port.
//   Ports:
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     clear      synchronous abort back to IDLE (wins over start)
//     start      begin a neuron (IDLE only); bias captured on the same edge
//     bias       signed bias
//     in_valid / in_ready / in_data / in_weight   input beat stream
//     out_valid / out_ready / out_data / overflow result stream
//     busy       FSM not in IDLE
//   in_ready, out_valid and busy are decoded from the state register only,
//   so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module neuron_stream_pe
  import neuron_pkg::*;
#(
  parameter int IN_SIZE   = 196,
  parameter int LANES     = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_W   = 8,
  parameter int WIDTH_B   = 8,
  parameter int WIDTH_ACC = 24,
  parameter int WIDTH_OUT = 16,
  parameter int RELU      = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        start,
  input  logic signed [WIDTH_B-1:0]   bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*WIDTH_IN-1:0]   in_data,
  input  logic [LANES*WIDTH_W-1:0]    in_weight,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_OUT-1:0] out_data,
  output logic                        overflow,
  output logic                        busy
);

  localparam int BEATS = IN_SIZE / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W = WIDTH_IN + WIDTH_W + $clog2(LANES) + 1;
  // One extra bit so acc + bias can never wrap before saturation.
  localparam int R_W   = WIDTH_ACC + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Elaboration-time parameter checks
  if (LANES < 1 || IN_SIZE < LANES || (IN_SIZE % LANES) != 0) begin : g_bad_size
    $error("neuron_stream_pe: IN_SIZE must be a positive multiple of LANES");
  end
  if (!acc_width_ok(WIDTH_ACC, WIDTH_IN, WIDTH_W, WIDTH_B, WIDTH_OUT, IN_SIZE)) begin : g_bad_acc
    $error("neuron_stream_pe: WIDTH_ACC too small for IN_SIZE/WIDTH_IN/WIDTH_W/WIDTH_B/WIDTH_OUT");
  end

  state_e                      state_q,    state_d;
  logic signed [WIDTH_ACC-1:0] acc_q,      acc_d;
  logic        [CNT_W-1:0]     cnt_q,      cnt_d;
  logic signed [WIDTH_B-1:0]   bias_q,     bias_d;
  logic signed [WIDTH_OUT-1:0] out_data_q, out_data_d;
  logic                        overflow_q, overflow_d;

  logic signed [SUM_W-1:0] lane_sum;
  logic signed [R_W-1:0]   biased;
  logic signed [R_W-1:0]   rectified;
  sat_t                    sat;
  logic                    unused_sat_bits;

  lane_dot_sum #(
    .LANES    (LANES),
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_W  (WIDTH_W)
  ) u_dot (
    .in_data   (in_data),
    .in_weight (in_weight),
    .sum       (lane_sum)
  );

  // Output stage datapath; only registered while in FINISH.
  always_comb begin : output_stage
    biased    = R_W'(acc_q) + R_W'(bias_q);
    rectified = biased;
    // ReLU zeroing happens before saturation, so it never raises overflow.
    if (RELU != 0 && biased < 0) begin
      rectified = '0;
    end
    sat = saturate(SAT_W'(rectified), WIDTH_OUT);
  end

  // Clamped value always fits WIDTH_OUT; upper bits are sign copies.
  assign unused_sat_bits = ^sat.value[SAT_W-1:WIDTH_OUT];

  always_comb begin : next_state
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;

    if (clear) begin
      // Abort: drop the partial result and ignore any beat this cycle.
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            bias_d  = bias;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            // The WIDTH_ACC check guarantees lane_sum fits the accumulator.
            acc_d = acc_q + WIDTH_ACC'(lane_sum);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_d = S_FINISH;
            end
          end
        end
        S_FINISH: begin
          out_data_d = sat.value[WIDTH_OUT-1:0];
          overflow_d = sat.flag;
          state_d    = S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_neuron_stream_pe.sv
// -----------------------------------------------------------------------------
// tb_neuron_stream_pe
//   Two instances (RELU=1 and RELU=0) share one stimulus stream. Expected
//   results are pushed into per-instance queues when a neuron is issued; a
//   negedge monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_neuron_stream_pe;

  localparam int IN_SIZE   = 8;
  localparam int LANES     = 4;
  localparam int WIDTH_IN  = 8;
  localparam int WIDTH_W   = 8;
  localparam int WIDTH_B   = 8;
  localparam int WIDTH_ACC = 24;
  localparam int WIDTH_OUT = 8;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic clear     = 1'b0;
  logic start     = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic [WIDTH_B-1:0]        bias      = '0;
  logic [LANES*WIDTH_IN-1:0] in_data   = '0;
  logic [LANES*WIDTH_W-1:0]  in_weight = '0;

  logic                 r_in_ready, r_out_valid, r_overflow, r_busy;
  logic [WIDTH_OUT-1:0] r_out_data;
  logic                 l_in_ready, l_out_valid, l_overflow, l_busy;
  logic [WIDTH_OUT-1:0] l_out_data;

  always #5 clk = ~clk;

  neuron_stream_pe #(
    .IN_SIZE(IN_SIZE), .LANES(LANES), .WIDTH_IN(WIDTH_IN), .WIDTH_W(WIDTH_W),
    .WIDTH_B(WIDTH_B), .WIDTH_ACC(WIDTH_ACC), .WIDTH_OUT(WIDTH_OUT), .RELU(1)
  ) u_dut_relu (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .in_weight(in_weight), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_data(r_out_data), .overflow(r_overflow), .busy(r_busy)
  );

  neuron_stream_pe #(
    .IN_SIZE(IN_SIZE), .LANES(LANES), .WIDTH_IN(WIDTH_IN), .WIDTH_W(WIDTH_W),
    .WIDTH_B(WIDTH_B), .WIDTH_ACC(WIDTH_ACC), .WIDTH_OUT(WIDTH_OUT), .RELU(0)
  ) u_dut_lin (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .in_weight(in_weight), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_data(l_out_data), .overflow(l_overflow), .busy(l_busy)
  );

  typedef struct {
    int data;
    int ov;
  } exp_t;

  exp_t q_r[$];
  exp_t q_l[$];
  exp_t er, el;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   hs_r   = 0;
  int   hs_l   = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake completes on the next posedge whenever
  // out_valid && out_ready is seen here.
  always @(negedge clk) begin
    if (reset_n && out_ready && r_out_valid) begin
      hs_r++;
      if (q_r.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL relu_extra_output: got out_data=%0d, required no output",
                 $signed(r_out_data));
      end else begin
        er = q_r.pop_front();
        $display("relu txn %0d: out_data=%0d overflow=%0d (expect %0d/%0d)",
                 hs_r, $signed(r_out_data), r_overflow, er.data, er.ov);
        check("relu_out_data", $signed(r_out_data), er.data);
        check("relu_overflow", r_overflow, er.ov);
      end
    end
    if (reset_n && out_ready && l_out_valid) begin
      hs_l++;
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lin_extra_output: got out_data=%0d, required no output",
                 $signed(l_out_data));
      end else begin
        el = q_l.pop_front();
        $display("lin  txn %0d: out_data=%0d overflow=%0d (expect %0d/%0d)",
                 hs_l, $signed(l_out_data), l_overflow, el.data, el.ov);
        check("lin_out_data", $signed(l_out_data), el.data);
        check("lin_overflow", l_overflow, el.ov);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int d, input int w);
    for (int k = 0; k < LANES; k++) begin
      in_data[k*WIDTH_IN +: WIDTH_IN] = WIDTH_IN'(d);
      in_weight[k*WIDTH_W +: WIDTH_W] = WIDTH_W'(w);
    end
  endtask

  task automatic push(input int rd, input int ro, input int ld, input int lo);
    exp_t e;
    e.data = rd; e.ov = ro; q_r.push_back(e);
    e.data = ld; e.ov = lo; q_l.push_back(e);
    pushed++;
  endtask

  task automatic start_neuron(input int b);
    bias  = WIDTH_B'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int d, input int w);
    set_lanes(d, w);
    in_valid = 1'b1;
    check("in_ready_relu", r_in_ready, 1);
    check("in_ready_lin", l_in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Full neuron with continuous valid and out_ready held high.
  task automatic run_basic(input string tag, input int d, input int w, input int b,
                           input int rd, input int ro, input int ld, input int lo);
    out_ready = 1'b1;
    push(rd, ro, ld, lo);
    start_neuron(b);
    beat(d, w);
    beat(d, w);
    check({tag, "_finish_no_valid"}, r_out_valid, 0);
    tick();
    check({tag, "_valid_relu"}, r_out_valid, 1);
    check({tag, "_valid_lin"}, l_out_valid, 1);
    tick();
    check({tag, "_valid_dropped"}, r_out_valid, 0);
    check({tag, "_idle_busy"}, r_busy, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_in_ready", r_in_ready, 0);
    check("rst_out_valid", r_out_valid, 0);
    check("rst_out_data", $signed(r_out_data), 0);
    check("rst_overflow", r_overflow, 0);
    check("rst_busy", l_busy, 0);
    #2 reset_n = 1'b1;
    tick();

    // Directed vectors: data, weight, bias, relu result/ovf, linear result/ovf
    run_basic("ones",    1,    1,    0,   8, 0,    8, 0);
    run_basic("pos_sat", 127,  127,  5, 127, 1,  127, 1);
    run_basic("neg_sat", -128, 127,  0,   0, 0, -128, 1);
    run_basic("neg_lin", 1,    -1,  -3,   0, 0,  -11, 0);

    // Gapped input, ignored starts, held output
    out_ready = 1'b0;
    push(8, 0, 8, 0);
    start_neuron(0);
    beat(1, 1);
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("gap_in_ready", r_in_ready, 1);
    tick();
    beat(1, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", r_out_valid, 1);
      check("hold_data_relu", $signed(r_out_data), 8);
      check("hold_data_lin", $signed(l_out_data), 8);
      check("hold_overflow", r_overflow, 0);
      start = (i == 2);
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    check("hold_done_valid", r_out_valid, 0);
    check("hold_done_busy", r_busy, 0);

    // Asynchronous reset mid-accumulation
    start_neuron(0);
    beat(1, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", r_busy, 0);
    check("arst_in_ready", r_in_ready, 0);
    check("arst_out_data_relu", $signed(r_out_data), 0);
    check("arst_out_data_lin", $signed(l_out_data), 0);
    check("arst_overflow", l_overflow, 0);
    #2 reset_n = 1'b1;
    tick();
    run_basic("post_rst", 1, 1, 0, 8, 0, 8, 0);

    // clear beats start in the same cycle
    bias  = 8'd0;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("clr_start_busy", r_busy, 0);

    // clear with a beat presented in ACCUM
    start_neuron(5);
    beat(1, 1);
    set_lanes(1, 1);
    in_valid = 1'b1;
    clear    = 1'b1;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clr_accum_busy", r_busy, 0);
    check("clr_accum_in_ready", r_in_ready, 0);
    run_basic("post_clr_acc", 1, -1, -3, 0, 0, -11, 0);

    // clear in HOLD
    out_ready = 1'b0;
    start_neuron(0);
    beat(127, 127);
    beat(127, 127);
    tick();
    check("clr_hold_valid_before", r_out_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hold_valid_after", r_out_valid, 0);
    check("clr_hold_busy", l_busy, 0);
    run_basic("post_clr_hold", 1, 1, 0, 8, 0, 8, 0);

    tick();
    check("queue_relu_empty", q_r.size(), 0);
    check("queue_lin_empty", q_l.size(), 0);
    check("handshakes_relu", hs_r, pushed);
    check("handshakes_lin", hs_l, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units, required completion");
    $fatal(1);
  end

endmodule
